// File: rtl/hft_pkg.sv
// Shared types for the price signal path: price width, FSM state encoding, signal direction.
package hft_pkg;

  localparam int unsigned DATA_W = 16;

  typedef logic [DATA_W-1:0] price_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_CALC = 2'd2,
    ST_EMIT = 2'd3
  } fsm_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_BUY  = 2'd1,
    DIR_SELL = 2'd2
  } sig_dir_e;

  // One extra bit keeps mean+thresh from wrapping; sample+thresh<mean avoids a negative mean-thresh.
  function automatic sig_dir_e classify(input price_t sample, input price_t mean, input price_t thresh);
    logic [DATA_W:0] s;
    logic [DATA_W:0] m;
    logic [DATA_W:0] t;
    s = {1'b0, sample};
    m = {1'b0, mean};
    t = {1'b0, thresh};
    if (s > m + t) return DIR_SELL;
    if (s + t < m) return DIR_BUY;
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/window_ring.sv
// Moving-window store: ring of the last 2^WIN_LOG2 prices, running sum, fill tracking and mean.
module window_ring
  import hft_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] mean,
  output logic              full
);

  localparam int unsigned DEPTH = 1 << WIN_LOG2;
  localparam int unsigned SUM_W = DATA_W + WIN_LOG2;

  price_t              slots [DEPTH];
  logic [WIN_LOG2-1:0] wr_ptr;
  logic [WIN_LOG2-1:0] fill;
  logic [SUM_W-1:0]    sum;
  price_t              oldest_c;

  assign oldest_c = slots[wr_ptr];
  assign mean     = sum[SUM_W-1:WIN_LOG2];

  // Slots start at zero so the oldest value subtracted during warm-up contributes nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) slots[i] <= '0;
      wr_ptr <= '0;
      fill   <= '0;
      full   <= 1'b0;
      sum    <= '0;
    end else if (wr_en) begin
      slots[wr_ptr] <= wr_data;
      wr_ptr        <= wr_ptr + WIN_LOG2'(1);
      sum           <= sum - SUM_W'(oldest_c) + SUM_W'(wr_data);
      if (!full) begin
        fill <= fill + WIN_LOG2'(1);
        if (fill == '1) full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/price_signal_engine.sv
// Pops prices from the queue, tracks the moving average and flags mean-reversion buy/sell.
// Optional same-direction cooldown is built when SIG_COOLDOWN_EN is defined.
module price_signal_engine
  import hft_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = 3,
  parameter int unsigned THRESH   = 16
`ifdef SIG_COOLDOWN_EN
  ,
  parameter int unsigned COOLDOWN = 4
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              q_empty,
  output logic              q_pop,
  input  logic [DATA_W-1:0] q_read_value,
  output logic              sig_valid,
  output logic              sig_buy,
  output logic              sig_sell,
  output logic [DATA_W-1:0] avg,
  output logic              warm
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] WAIT = ST_WAIT;
  localparam logic [1:0] CALC = ST_CALC;
  localparam logic [1:0] EMIT = ST_EMIT;

  logic [1:0] state;
  logic [1:0] state_next;
  price_t     sample;
  sig_dir_e   dir_raw_c;
  sig_dir_e   dir_c;
  logic       ring_wr_c;
  logic       judge_c;

  assign ring_wr_c = (state == CALC);
  assign judge_c   = ring_wr_c && warm;
  assign dir_raw_c = classify(sample, avg, DATA_W'(THRESH));

  window_ring #(.WIN_LOG2(WIN_LOG2)) u_ring (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ring_wr_c),
    .wr_data (sample),
    .mean    (avg),
    .full    (warm)
  );

  // Pop is a same-cycle strobe so the queue sees it only while it reports non-empty.
  always_comb begin
    state_next = state;
    q_pop      = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !q_empty) begin
          q_pop      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT:    state_next = CALC;
      CALC:    state_next = EMIT;
      EMIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef SIG_COOLDOWN_EN
  localparam int unsigned CD_W = $clog2(COOLDOWN + 1);

  logic [CD_W-1:0] cool_cnt;
  sig_dir_e        last_dir;

  assign dir_c = (dir_raw_c == last_dir && cool_cnt != '0) ? DIR_NONE : dir_raw_c;

  // A fresh signal in either direction re-arms the window against that direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      cool_cnt <= '0;
      last_dir <= DIR_NONE;
    end else if (judge_c) begin
      if (dir_c != DIR_NONE) begin
        last_dir <= dir_c;
        cool_cnt <= CD_W'(COOLDOWN);
      end else if (cool_cnt != '0) begin
        cool_cnt <= cool_cnt - CD_W'(1);
      end
    end
  end
`else
  assign dir_c = dir_raw_c;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sample    <= '0;
      sig_valid <= 1'b0;
      sig_buy   <= 1'b0;
      sig_sell  <= 1'b0;
    end else begin
      state     <= state_next;
      sig_valid <= 1'b0;
      if (state == WAIT) sample <= q_read_value;
      // Judged against the pre-update average; result is visible during EMIT.
      if (judge_c) begin
        sig_valid <= 1'b1;
        sig_buy   <= (dir_c == DIR_BUY);
        sig_sell  <= (dir_c == DIR_SELL);
      end
    end
  end

endmodule

// File: tb/tb_price_signal_engine.sv
// Directed bench for price_signal_engine; expectations follow the SIG_COOLDOWN_EN setting.
module tb_price_signal_engine;

`ifdef SIG_COOLDOWN_EN
  localparam bit CD = 1'b1;
`else
  localparam bit CD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        q_empty;
  logic        q_pop;
  logic [15:0] q_read_value;
  logic        sig_valid;
  logic        sig_buy;
  logic        sig_sell;
  logic [15:0] avg;
  logic        warm;

  int errors = 0;
  int checks = 0;

  logic        r_pop, r_early, r_sv, r_buy, r_sell, r_warm;
  logic [15:0] r_avg;
  int          r_wait;

  always #5 clk = ~clk;

  price_signal_engine dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .q_empty      (q_empty),
    .q_pop        (q_pop),
    .q_read_value (q_read_value),
    .sig_valid    (sig_valid),
    .sig_buy      (sig_buy),
    .sig_sell     (sig_sell),
    .avg          (avg),
    .warm         (warm)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer one price; record pop, early/late sig_valid and outputs in the EMIT cycle.
  task automatic push(input logic [15:0] price);
    r_pop = 0; r_early = 0; r_sv = 0; r_buy = 0; r_sell = 0; r_warm = 0; r_avg = '0; r_wait = 0;
    @(posedge clk); #1;
    q_read_value = price;
    q_empty      = 1'b0;
    for (int i = 0; i < 20 && !r_pop; i++) begin
      @(negedge clk);
      r_wait++;
      if (q_pop) r_pop = 1'b1;
    end
    @(posedge clk); #1;
    q_empty = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) begin
        if (sig_valid) r_early = 1'b1;
      end else begin
        r_sv = sig_valid; r_buy = sig_buy; r_sell = sig_sell; r_avg = avg; r_warm = warm;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int pops;
    int vcnt;
    rst = 1'b1; enable = 1'b1; q_empty = 1'b1; q_read_value = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_q_pop", q_pop, 0);
    check("rst_sig_valid", sig_valid, 0);
    check("rst_buy_sell", {sig_buy, sig_sell}, 0);
    check("rst_avg", avg, 0);
    check("rst_warm", warm, 0);

    // Warm-up with a flat price
    pops = 0; vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      push(16'd1000);
      pops += int'(r_pop);
      vcnt += int'(r_sv | r_early);
      if (i == 6) check("warm_after_7", r_warm, 0);
    end
    check("warmup_pops", pops, 8);
    check("warmup_no_valid", vcnt, 0);
    check("warm_on_8th", r_warm, 1);
    check("warmup_avg", r_avg, 1000);

    push(16'd1020);
    check("sell_valid", r_sv, 1);
    check("sell_latency", r_early, 0);
    check("sell_flags", {r_buy, r_sell}, 2'b01);
    check("sell_avg", r_avg, 1002);
    push(16'd980);
    check("buy_valid", r_sv, 1);
    check("buy_flags", {r_buy, r_sell}, 2'b10);
    check("buy_avg", r_avg, 1000);

    // Exactly avg+THRESH is not a sell
    push(16'd1016);
    check("eq_hi_valid", r_sv, 1);
    check("eq_hi_flags", {r_buy, r_sell}, 2'b00);
    check("eq_hi_avg", r_avg, 1002);
    for (int i = 0; i < 8; i++) push(16'd1000);
    check("refill_avg", r_avg, 1000);
    // Exactly avg-THRESH is not a buy
    push(16'd984);
    check("eq_lo_valid", r_sv, 1);
    check("eq_lo_flags", {r_buy, r_sell}, 2'b00);
    check("eq_lo_avg", r_avg, 998);

    // Empty queue: no pops
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (q_pop) pops++;
    end
    check("empty_no_pop", pops, 0);
    push(16'd998);
    check("release_pop_first_cycle", r_wait, 1);
    check("release_valid_3", r_sv, 1);
    check("release_no_early", r_early, 0);
    check("release_flags", {r_buy, r_sell}, 2'b00);
    check("release_avg", r_avg, 997);

    // Reset right after a pop discards the in-flight sample
    @(posedge clk); #1;
    q_read_value = 16'd5000;
    q_empty      = 1'b0;
    @(negedge clk);
    check("pop_before_rst", q_pop, 1);
    @(posedge clk); #1;
    q_empty = 1'b1;
    rst     = 1'b1;
    @(posedge clk); #1;
    rst  = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sig_valid) vcnt++;
    end
    check("rst_inflight_no_valid", vcnt, 0);
    check("rst_inflight_avg", avg, 0);
    check("rst_inflight_warm", warm, 0);
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      push(16'd500);
      vcnt += int'(r_sv | r_early);
      if (i == 6) check("rewarm_after_7", r_warm, 0);
    end
    check("rewarm_no_valid", vcnt, 0);
    check("rewarm_warm", r_warm, 1);
    check("rewarm_avg", r_avg, 500);

    // enable low blocks new pops
    @(posedge clk); #1;
    enable  = 1'b0;
    q_empty = 1'b0;
    pops    = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (q_pop) pops++;
    end
    check("disabled_no_pop", pops, 0);
    q_empty = 1'b1;
    enable  = 1'b1;

    // Repeated sells: cooldown suppresses repeats only when built in
    do_reset();
    for (int i = 0; i < 8; i++) push(16'd1000);
    push(16'd1100);
    check("cd_first_sell", {r_sv, r_buy, r_sell}, 3'b101);
    check("cd_first_avg", r_avg, 1012);
    push(16'd1100);
    check("cd_second_sell", {r_sv, r_buy, r_sell}, {1'b1, 1'b0, !CD});
    check("cd_second_avg", r_avg, 1025);
    push(16'd1100);
    check("cd_third_sell", {r_sv, r_buy, r_sell}, {1'b1, 1'b0, !CD});
    check("cd_third_avg", r_avg, 1037);
    push(16'd900);
    check("cd_opposite_buy", {r_sv, r_buy, r_sell}, 3'b110);
    check("cd_opposite_avg", r_avg, 1025);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/price_signal_engine.md
Name: price_signal_engine

Overview:
- Downstream consumer of the 16-bit price queue: pops one price at a time and keeps an 8-sample moving average.
- Flags mean-reversion buy/sell signals when a new price deviates from the average by more than a threshold.
- Sits between the price queue and the order-generation logic; all outputs registered.

Parameters:
- DATA_W, 16, price width; matches queue write_value/read_value.
- WIN_LOG2, 3, log2 of averaging window (window = 8 samples).
- THRESH, 16, unsigned deviation threshold in price LSBs.
- COOLDOWN, 4, samples of same-direction suppression (used only with optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  allows new pops; 0 = finish current sample, then hold in IDLE.
- q_empty  in  1  queue empty flag; no pop while high.
- q_pop  out  1  one-cycle pop strobe to queue.
- q_read_value  in  DATA_W  queue data, valid exactly one cycle after q_pop.
- sig_valid  out  1  one-cycle strobe per processed sample once window is full.
- sig_buy  out  1  qualified by sig_valid: price < avg − THRESH.
- sig_sell  out  1  qualified by sig_valid: price > avg + THRESH.
- avg  out  DATA_W  current window average (sum >> WIN_LOG2, truncating).
- warm  out  1  high once 2^WIN_LOG2 samples have been absorbed.

Behaviour:
- Reset: all outputs 0, sum 0, ring pointer 0, fill count 0, FSM to IDLE. Applies mid-operation; an in-flight popped sample is discarded.
- FSM states and transitions:
  - IDLE: if enable && !q_empty, drive q_pop=1 for this cycle and go to WAIT.
  - WAIT: latch q_read_value into sample register, go to CALC.
  - CALC: compare sample against the pre-update avg; update ring (overwrite oldest), sum = sum − oldest + sample; increment fill count, saturating at 2^WIN_LOG2; go to EMIT.
  - EMIT: if warm was already high before this sample, pulse sig_valid with sig_buy/sig_sell. Return to IDLE.
- Throughput: one sample per 4 cycles. Latency: q_pop to sig_valid = 3 cycles.
- Arithmetic:
  - sum is DATA_W+WIN_LOG2 bits unsigned, no overflow possible.
  - Comparisons use DATA_W+1 bits; avg+THRESH never wraps, and avg−THRESH below 0 means no buy.
  - Comparisons are strict, so equality yields no signal. sig_buy and sig_sell are never both 1.
- Warm-up: the first 2^WIN_LOG2 samples only fill the ring (ring slots reset to 0, so oldest=0 during fill). warm rises in the EMIT of the 8th sample; sig_valid stays 0 through that sample.
- q_pop is never asserted outside IDLE and never while q_empty=1. Deasserting enable does not abort an in-progress sample.
- sig_buy/sig_sell hold their value until the next sig_valid; consumers sample only on sig_valid.

Optional Feature:
- Macro SIG_COOLDOWN_EN.
- Defined: after a sig_buy (or sig_sell), the same direction is suppressed for the next COOLDOWN warm samples. A counter decrements per sample and resets on an opposite-direction signal; the opposite direction is never suppressed. sig_valid still pulses.
- Undefined: no counter; every qualifying sample signals.

Decomposition:
- Package hft_pkg: DATA_W constant, price_t typedef (logic [DATA_W-1:0]), FSM state enum (IDLE/WAIT/CALC/EMIT), sig_dir enum (NONE/BUY/SELL).
- One sub-module, window_ring: ring buffer, write pointer, running sum, fill count, and oldest-sample output. The engine owns the FSM, comparisons, and cooldown.

Test Plan:
- Reset, then 8 samples of 1000 → 8 q_pop pulses, sig_valid never high, warm=1, avg=1000.
- Warm window at 1000, push 1020 → sig_valid with sig_sell=1, sig_buy=0; avg then 1002. Push 980 → sig_buy=1 (980 < 1002−16).
- Warm at avg 1000, push 1016 and 984 → sig_valid pulses, both signals 0 (strict boundary).
- Hold q_empty=1 for 20 cycles → q_pop stays 0, FSM stays in IDLE. Release → pop on the first cycle q_empty=0, sig_valid exactly 3 cycles later.
- Assert rst the cycle after q_pop → no sig_valid; avg=0, warm=0; the next 8 samples restart warm-up.
- With SIG_COOLDOWN_EN at avg ≈1000: push 1100, 1100, 1100 → only the first asserts sig_sell. A following 900 still asserts sig_buy.
